// File: rtl/adder_byte_sequencer.sv
// rtl/adder_byte_sequencer.sv - byte-serial multi-byte adder sequencer around an external 8-bit adder (optional feature macro: ADDER_SEQ_OVERFLOW_EN)
module adder_byte_sequencer #(
    parameter int NUM_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_cin,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_cout,
    output logic       out_last
`ifdef ADDER_SEQ_OVERFLOW_EN
    ,
    output logic       out_ovf
`endif
);

    // A 1-byte word still needs a one-bit index register
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ADD    = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             carry_q, carry_d;
    logic [7:0]       add_a_q, add_a_d;
    logic [7:0]       add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [7:0]       out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_last_q, out_last_d;
    logic             is_last;
`ifdef ADDER_SEQ_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    assign is_last = (byte_idx_q == LAST_IDX);

    // State and datapath registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCEPT;
            byte_idx_q <= '0;
            carry_q    <= 1'b0;
            add_a_q    <= 8'h00;
            add_b_q    <= 8'h00;
            add_cin_q  <= 1'b0;
            out_sum_q  <= 8'h00;
            out_cout_q <= 1'b0;
            out_last_q <= 1'b0;
`ifdef ADDER_SEQ_OVERFLOW_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            carry_q    <= carry_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_last_q <= out_last_d;
`ifdef ADDER_SEQ_OVERFLOW_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Next-state and register-update logic; everything holds unless its state acts on it
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        carry_d    = carry_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_cin_d  = add_cin_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_last_d = out_last_q;
`ifdef ADDER_SEQ_OVERFLOW_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            ST_ACCEPT: begin
                if (in_valid) begin
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    // Byte 0 starts a new word, so the stored carry must not leak in
                    add_cin_d = (byte_idx_q == '0) ? in_cin : carry_q;
                    state_d   = ST_ADD;
                end
            end
            ST_ADD: begin
                // Operands were registered last cycle, so the adder output has settled
                out_sum_d  = add_sum;
                out_cout_d = add_cout;
                carry_d    = add_cout;
                out_last_d = is_last;
`ifdef ADDER_SEQ_OVERFLOW_EN
                ovf_d      = is_last && (add_a_q[7] == add_b_q[7]) && (add_sum[7] != add_a_q[7]);
`endif
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    byte_idx_d = is_last ? '0 : byte_idx_q + IDX_W'(1);
                    state_d    = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    assign in_ready  = (state_q == ST_ACCEPT);
    assign out_valid = (state_q == ST_EMIT);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_last  = out_last_q;
`ifdef ADDER_SEQ_OVERFLOW_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_byte_sequencer.sv
// tb/tb_adder_byte_sequencer.sv - directed table-driven bench for adder_byte_sequencer
module tb_adder_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    // 4-byte instance
    logic       in_valid4, in_ready4, in_cin4, add_cin4, add_cout4;
    logic [7:0] in_a4, in_b4, add_a4, add_b4, add_sum4, out_sum4;
    logic       out_valid4, out_ready4, out_cout4, out_last4;
`ifdef ADDER_SEQ_OVERFLOW_EN
    logic       out_ovf4;
`endif

    // 1-byte instance
    logic       in_valid1, in_ready1, in_cin1, add_cin1, add_cout1;
    logic [7:0] in_a1, in_b1, add_a1, add_b1, add_sum1, out_sum1;
    logic       out_valid1, out_ready1, out_cout1, out_last1;
`ifdef ADDER_SEQ_OVERFLOW_EN
    logic       out_ovf1;
`endif

    // External simple 8-bit adders
    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {8'h00, add_cin4};
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'h00, add_cin1};

    adder_byte_sequencer #(.NUM_BYTES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_sum(add_sum4), .add_cout(add_cout4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .out_cout(out_cout4),
        .out_last(out_last4)
`ifdef ADDER_SEQ_OVERFLOW_EN
        , .out_ovf(out_ovf4)
`endif
    );

    adder_byte_sequencer #(.NUM_BYTES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1),
        .out_last(out_last1)
`ifdef ADDER_SEQ_OVERFLOW_EN
        , .out_ovf(out_ovf1)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       l;
        int         stall;
    } vec_t;

    vec_t tbl [20];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat to dut4, wait for acceptance, then measure latency to out_valid
    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int wt;
        int lat;
        in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
        wt = 0;
        while (!in_ready4 && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk("accept_timeout", 32'(wt >= 20), 32'(0));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid4 = 1'b0;
            lat++;
        end while (!out_valid4 && lat < 20);
        chk("latency", 32'(lat), 32'(2));
    endtask

    // Check the presented result byte, optionally stall, then complete the handshake
    task automatic recv4(input logic [7:0] s, input logic c, input logic l, input int stall);
        logic stable;
        chk("out_sum", 32'(out_sum4), 32'(s));
        chk("out_cout", 32'(out_cout4), 32'(c));
        chk("out_last", 32'(out_last4), 32'(l));
        if (stall > 0) begin
            stable = 1'b1;
            in_a4 = 8'hAA; in_b4 = 8'h55; in_cin4 = 1'b1; in_valid4 = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (!out_valid4 || in_ready4 || out_sum4 !== s || out_cout4 !== c || out_last4 !== l)
                    stable = 1'b0;
            end
            in_valid4 = 1'b0;
            chk("stall_stable", 32'(stable), 32'(1));
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    initial begin
        int lat;
        // 0x000000FF + 0x00000001, cin=0 (in_cin driven 1 on later bytes; must be ignored)
        tbl[0]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[1]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0};
        tbl[2]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 0};
        tbl[3]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 0};
        // 0xFFFFFFFF + 0x00000000, cin=1
        tbl[4]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0};
        tbl[5]  = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[6]  = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[7]  = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 0};
        // 0xFFFFFFFF + 0x00000001, cin=0
        tbl[8]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[9]  = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[10] = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[11] = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 0};
        // back-to-back 0x00000000 + 0x00000000, cin=0: leftover carry must not leak
        tbl[12] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[13] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[14] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[15] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 0};
        // 0x12345678 + 0x11111111, cin=0, 5-cycle stall on byte 1
        tbl[16] = '{8'h78, 8'h11, 1'b0, 8'h89, 1'b0, 1'b0, 0};
        tbl[17] = '{8'h56, 8'h11, 1'b1, 8'h67, 1'b0, 1'b0, 5};
        tbl[18] = '{8'h34, 8'h11, 1'b1, 8'h45, 1'b0, 1'b0, 0};
        tbl[19] = '{8'h12, 8'h11, 1'b1, 8'h23, 1'b0, 1'b1, 0};

        rst = 1'b1;
        in_valid4 = 1'b0; in_a4 = 8'h00; in_b4 = 8'h00; in_cin4 = 1'b0; out_ready4 = 1'b0;
        in_valid1 = 1'b0; in_a1 = 8'h00; in_b1 = 8'h00; in_cin1 = 1'b0; out_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_in_ready", 32'(in_ready4), 32'(1));
        chk("rst_out_valid", 32'(out_valid4), 32'(0));
        chk("rst_add_ops", {15'h0, add_cin4, add_a4, add_b4}, 32'(0));
        chk("rst_out", {22'h0, out_last4, out_cout4, out_sum4}, 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            send4(tbl[i].a, tbl[i].b, tbl[i].cin);
            recv4(tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].stall);
        end

        // Reset after two beats; the third beat is sitting in EMIT with out_ready high
        send4(8'h01, 8'h01, 1'b0);
        recv4(8'h02, 1'b0, 1'b0, 0);
        send4(8'h03, 8'h04, 1'b0);
        recv4(8'h07, 1'b0, 1'b0, 0);
        send4(8'h80, 8'h80, 1'b0);
        rst = 1'b1;
        out_ready4 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready4 = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid4), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready4), 32'(1));
        chk("mid_rst_out", {22'h0, out_last4, out_cout4, out_sum4}, 32'(0));
        send4(8'h00, 8'h00, 1'b1);
        recv4(8'h01, 1'b0, 1'b0, 0);
        send4(8'h00, 8'h00, 1'b0);
        recv4(8'h00, 1'b0, 1'b0, 0);
        send4(8'h00, 8'h00, 1'b0);
        recv4(8'h00, 1'b0, 1'b0, 0);
        send4(8'h00, 8'h00, 1'b0);
        recv4(8'h00, 1'b0, 1'b1, 0);

        // Single-byte instance: 0x7F + 0x01, cin=0
        in_a1 = 8'h7F; in_b1 = 8'h01; in_cin1 = 1'b0; in_valid1 = 1'b1;
        chk("nb1_in_ready", 32'(in_ready1), 32'(1));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid1 = 1'b0;
            lat++;
        end while (!out_valid1 && lat < 20);
        chk("nb1_latency", 32'(lat), 32'(2));
        chk("nb1_out_sum", 32'(out_sum1), 32'(8'h80));
        chk("nb1_out_cout", 32'(out_cout1), 32'(0));
        chk("nb1_out_last", 32'(out_last1), 32'(1));
`ifdef ADDER_SEQ_OVERFLOW_EN
        chk("nb1_out_ovf", 32'(out_ovf1), 32'(1));
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;

        // Second single-byte word: every beat is byte 0, so in_cin applies
        in_a1 = 8'h01; in_b1 = 8'h01; in_cin1 = 1'b1; in_valid1 = 1'b1;
        chk("nb1_in_ready2", 32'(in_ready1), 32'(1));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid1 = 1'b0;
            lat++;
        end while (!out_valid1 && lat < 20);
        chk("nb1_latency2", 32'(lat), 32'(2));
        chk("nb1_out_sum2", 32'(out_sum1), 32'(8'h03));
        chk("nb1_out_last2", 32'(out_last1), 32'(1));
`ifdef ADDER_SEQ_OVERFLOW_EN
        chk("nb1_out_ovf2", 32'(out_ovf1), 32'(0));
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_byte_sequencer.md
ADDER_BYTE_SEQUENCER -- requirements
Module: adder_byte_sequencer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4: number of byte pairs per multi-byte addition, LSB byte first; legal range 1..16.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1: upstream operand beat valid.
REQ-005 SHALL have port in_ready  output  1: sequencer accepts the beat this cycle.
REQ-006 SHALL have ports in_a, in_b  input  8 each: operand bytes for the current beat.
REQ-007 SHALL have port in_cin  input  1: carry-in of the whole word; sampled only on byte 0.
REQ-008 SHALL have ports add_a, add_b  output  8 each, and add_cin  output  1: registered operands driving the external simple_8bit_adder.
REQ-009 SHALL have ports add_sum  input  8 and add_cout  input  1: combinational results from the external adder.
REQ-010 SHALL have ports out_valid  output  1 and out_ready  input  1: result-byte handshake.
REQ-011 SHALL have ports out_sum  output  8, out_cout  output  1 and out_last  output  1: result byte, that byte's carry-out, and a flag marking byte NUM_BYTES-1.

Function
REQ-012 SHALL implement a three-state FSM: ACCEPT, ADD, EMIT.
REQ-013 ACCEPT: in_ready=1; on in_valid, SHALL latch in_a/in_b into add_a/add_b, and SHALL set add_cin = in_cin if byte_idx==0, else carry_reg; next state ADD.
REQ-014 ADD: in_ready=0; SHALL capture add_sum into out_sum, add_cout into out_cout and carry_reg, and (byte_idx==NUM_BYTES-1) into out_last; next state EMIT.
REQ-015 EMIT: out_valid=1, in_ready=0; on out_ready, SHALL increment byte_idx (wrap to 0 after NUM_BYTES-1); next state ACCEPT.
REQ-016 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid high; minimum 3 cycles per byte.
REQ-017 While out_valid && !out_ready, out_sum, out_cout and out_last SHALL hold stable.
REQ-018 Carry SHALL NOT leak across words: byte 0 of every word uses in_cin, never carry_reg.
REQ-019 in_valid outside ACCEPT SHALL be ignored; upstream holds the beat.
REQ-020 The external adder is treated as zero-delay combinational within one cycle; no result SHALL be sampled in the same cycle as operand update.

Reset
REQ-021 On rst: state=ACCEPT, byte_idx=0, carry_reg=0, add_a=add_b=0, add_cin=0, out_sum=0, out_cout=0, out_last=0, out_valid=0.
REQ-022 Reset mid-word SHALL abandon the word; the next accepted beat is byte 0.
REQ-023 rst SHALL override any simultaneous handshake in that cycle.

Configuration
REQ-024 Macro ADDER_SEQ_OVERFLOW_EN SHALL add output out_ovf (1 bit) = signed overflow of the last byte: (add_a[7]==add_b[7]) && (add_sum[7]!=add_a[7]), captured in ADD only when out_last, else 0; reset 0.
REQ-025 Without ADDER_SEQ_OVERFLOW_EN, out_ovf SHALL not exist and behaviour is otherwise identical.

Verification
REQ-026 NUM_BYTES=4, word 0x000000FF+0x00000001, cin=0 -> bytes 00,01,00,00; out_cout 1,0,0,0; out_last only on 4th.
REQ-027 Word 0xFFFFFFFF+0x00000000, cin=1 -> all bytes 00, out_cout=1 on every byte, out_last on 4th.
REQ-028 out_ready held low 5 cycles in EMIT -> out_sum/out_cout/out_last stable, in_ready=0 throughout, no beat lost.
REQ-029 rst pulsed after 2 of 4 beats -> out_valid=0 next cycle; next beat uses in_cin as byte 0.
REQ-030 NUM_BYTES=1, 0x7F+0x01, cin=0 -> out_valid exactly 2 cycles after accept, out_sum=0x80, out_cout=0; with ADDER_SEQ_OVERFLOW_EN out_ovf=1.
REQ-031 Back-to-back words 0xFFFFFFFF+0x00000001 then 0x00000000+0x00000000 (cin=0) -> second word all 00, out_cout 0 on every byte.
